// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Radix-2 sequential MULT/MULTU/DIV/DIVU unit writing HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ZERO     = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_isDiv;
    logic                 r_zeroDiv;
    logic                 r_negRes;
    logic                 r_negRem;
    logic [WIDTH-1:0]     r_origA;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_negA;
    logic                 w_negB;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;
    logic [WIDTH:0]       w_mulSum;
    logic [2*WIDTH-1:0]   w_mulNext;
    logic [WIDTH:0]       w_remSh;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_divNext;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    // op[1] selects signed; the iterations always work on magnitudes.
    assign w_negA = op[1] & dataA[WIDTH-1];
    assign w_negB = op[1] & dataB[WIDTH-1];
    assign w_magA = w_negA ? -dataA : dataA;
    assign w_magB = w_negB ? -dataB : dataB;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mulNext = r_acc[0] ? {w_mulSum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring divide; the shifted remainder needs one extra bit before the trial.
    assign w_remSh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial   = w_remSh - {1'b0, r_b};
    assign w_divNext = w_trial[WIDTH] ? {w_remSh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_negRes ? -r_acc : r_acc;
    assign w_quo  = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_isDiv     <= 1'b0;
            r_zeroDiv   <= 1'b0;
            r_negRes    <= 1'b0;
            r_negRem    <= 1'b0;
            r_origA     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_isDiv     <= op[0];
                        r_zeroDiv   <= op[0] & (dataB == c_ZERO);
                        r_negRes    <= w_negA ^ w_negB;
                        r_negRem    <= w_negA;
                        r_origA     <= dataA;
                        r_a         <= w_magA;
                        r_b         <= w_magB;
                        r_acc       <= op[0] ? {c_ZERO, w_magA} : {c_ZERO, w_magB};
                        r_count     <= c_CNT_INIT;
                        div_by_zero <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= r_isDiv ? w_divNext : w_mulNext;
                    r_count <= r_count - c_CNT_ONE;
                    if (r_count == c_CNT_ONE) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    if (!r_isDiv) begin
                        {hi, lo} <= w_prod;
                    end else if (r_zeroDiv) begin
                        hi <= r_origA;
                        lo <= '1;
                    end else begin
                        hi <= w_rem;
                        lo <= w_quo;
                    end
                    div_by_zero <= r_zeroDiv;
                    done        <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Scoreboard bench for mul_div_unit at WIDTH=32 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        time         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [1:0]  op32 = 2'd0, op8 = 2'd0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;

    int   checks = 0;
    int   failures = 0;
    exp_t q32[$];
    exp_t q8[$];
    int   busyRun32 = 0, busyRun8 = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .dataA(a32), .dataB(b32),
        .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .dataA(a8), .dataB(b8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    // Reference: plain 64-bit signed/unsigned arithmetic truncated to w bits.
    function automatic exp_t model(input int w, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] mask, pu;
        longint      sa, sb, res;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a & mask[31:0]);
        sb = longint'(b & mask[31:0]);
        if (op[1] && a[w-1]) sa = sa - (longint'(1) << w);
        if (op[1] && b[w-1]) sb = sb - (longint'(1) << w);
        e.dbz = 1'b0;
        e.t   = 0;
        if (!op[0]) begin
            res  = sa * sb;
            pu   = res;
            e.lo = pu[31:0] & mask[31:0];
            pu   = pu >> w;
            e.hi = pu[31:0] & mask[31:0];
        end else if (sb == 0) begin
            e.dbz = 1'b1;
            e.lo  = mask[31:0];
            e.hi  = a & mask[31:0];
        end else begin
            res  = sa / sb;
            pu   = res;
            e.lo = pu[31:0] & mask[31:0];
            res  = sa % sb;
            pu   = res;
            e.hi = pu[31:0] & mask[31:0];
        end
        return e;
    endfunction

    task automatic waitIdle32();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy32) return;
        end
        checks++; failures++;
        $display("FAIL idle_timeout32 busy=%0b required 0", busy32);
    endtask

    task automatic waitIdle8();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy8) return;
        end
        checks++; failures++;
        $display("FAIL idle_timeout8 busy=%0b required 0", busy8);
    endtask

    task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        waitIdle32();
        start32 = 1'b1; op32 = o; a32 = a; b32 = b;
        @(posedge clk);
        e = model(32, o, a, b);
        e.t = $time + 33 * 10 + 5;
        q32.push_back(e);
        #1;
        start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        waitIdle8();
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(posedge clk);
        e = model(8, o, {24'd0, a}, {24'd0, b});
        e.t = $time + 9 * 10 + 5;
        q8.push_back(e);
        #1;
        start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q32.size() == 0 && q8.size() == 0) return;
        end
        checks++; failures++;
        $display("FAIL drain_timeout pending32=%0d pending8=%0d required 0", q32.size(), q8.size());
    endtask

    function automatic logic [31:0] pickB();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busyRun32 = 0;
        end else begin
            if (done32) begin
                checks++;
                if (q32.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done32 hi=%h lo=%h required no done", hi32, lo32);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    if (hi32 !== e.hi || lo32 !== e.lo || dbz32 !== e.dbz || $time != e.t) begin
                        failures++;
                        $display("FAIL result32 hi=%h lo=%h dbz=%b t=%0t required hi=%h lo=%h dbz=%b t=%0t",
                                 hi32, lo32, dbz32, $time, e.hi, e.lo, e.dbz, e.t);
                    end
                end
                checks++;
                if (busyRun32 != 33) begin
                    failures++;
                    $display("FAIL busy_len32 cycles=%0d required 33", busyRun32);
                end
            end
            if (busy32) busyRun32++;
            else busyRun32 = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busyRun8 = 0;
        end else begin
            if (done8) begin
                checks++;
                if (q8.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done8 hi=%h lo=%h required no done", hi8, lo8);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    if ({24'd0, hi8} !== e.hi || {24'd0, lo8} !== e.lo || dbz8 !== e.dbz || $time != e.t) begin
                        failures++;
                        $display("FAIL result8 hi=%h lo=%h dbz=%b t=%0t required hi=%h lo=%h dbz=%b t=%0t",
                                 hi8, lo8, dbz8, $time, e.hi[7:0], e.lo[7:0], e.dbz, e.t);
                    end
                end
                checks++;
                if (busyRun8 != 9) begin
                    failures++;
                    $display("FAIL busy_len8 cycles=%0d required 9", busyRun8);
                end
            end
            if (busy8) busyRun8++;
            else busyRun8 = 0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checks++;
        if ({hi32, lo32, busy32, done32, dbz32, hi8, lo8, busy8, done8, dbz8} !== '0) begin
            failures++;
            $display("FAIL reset_state hi32=%h lo32=%h busy=%b done=%b dbz=%b hi8=%h lo8=%h required all 0",
                     hi32, lo32, busy32, done32, dbz32, hi8, lo8);
        end
        rst_n = 1'b1;

        // Directed corner cases; consecutive issues land in the done cycle.
        issue32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue32(2'b10, 32'hFFFF_FFFD, 32'd5);
        issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue32(2'b01, 32'd100, 32'd7);
        issue32(2'b11, 32'hFFFF_FFF9, 32'd2);
        issue32(2'b11, 32'd7, 32'hFFFF_FFFE);
        issue32(2'b01, 32'h0000_1234, 32'd0);
        issue32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        issue32(2'b11, 32'hFFFF_FF00, 32'd0);

        // Starts while busy must be dropped.
        issue32(2'b00, 32'd12345, 32'd678);
        repeat (5) begin
            @(negedge clk);
            start32 = 1'b1; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        end
        @(negedge clk);
        start32 = 1'b0;

        for (int i = 0; i < 30; i++) begin
            issue32(2'($urandom_range(0, 3)), $urandom, pickB());
        end
        drain();

        // Reset in the middle of a multiply: outputs clear, no done follows.
        issue32(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        q32.delete();
        #1;
        checks++;
        if ({hi32, lo32, busy32, done32, dbz32} !== '0) begin
            failures++;
            $display("FAIL reset_abort hi=%h lo=%h busy=%b done=%b dbz=%b required all 0",
                     hi32, lo32, busy32, done32, dbz32);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        issue8(2'b01, 8'd200, 8'd9);
        issue8(2'b11, 8'h80, 8'hFF);
        issue8(2'b01, 8'h5A, 8'h00);
        for (int i = 0; i < 20; i++) begin
            issue8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
